// File: rtl/ram_behavior.sv
// ----------------------------------------------------------------------------
// ram_behavior
//   Behavioral simple dual-port RAM: one write port, one read port, one clock.
//   Depth is 2**AW words of DW bits. Writes commit on the rising edge of clk.
//   Reads are registered: r_data updates on the edge that samples r_en=1 and
//   holds until the next enabled read. A read and a write to the same address
//   on the same edge return the new write data (write-first bypass).
//
//   Optional feature (macro RAM_BEHAVIOR_RST_CLEAR_EN):
//     defined   - reset also clears every memory word to 0.
//     undefined - memory has no reset (plain RAM inference); only r_data is
//                 reset.
//
// Ports:
//   clk     in   1    clock, all state updates on the rising edge
//   rst_n   in   1    asynchronous active-low reset
//   w_en    in   1    write enable
//   w_addr  in   AW   write address
//   w_data  in   DW   write data
//   r_en    in   1    read enable
//   r_addr  in   AW   read address
//   r_data  out  DW   registered read data
// ----------------------------------------------------------------------------
module ram_behavior #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          w_en,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          r_en,
    input  logic [AW-1:0] r_addr,
    output logic [DW-1:0] r_data
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic          collide;
    logic [DW-1:0] rd_word;

    // Same-edge write to the read address wins over the stored word.
    assign collide = w_en && (w_addr == r_addr);
    assign rd_word = collide ? w_data : mem[r_addr];

`ifdef RAM_BEHAVIOR_RST_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end
`else
    // No reset on the array so it maps onto plain RAM; writes are still
    // blocked while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_en) begin
            mem[w_addr] <= w_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (r_en) begin
            r_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_ram_behavior.sv
// ----------------------------------------------------------------------------
// tb_ram_behavior
//   Self-checking bench for ram_behavior (AW=5, DW=8). A table of per-cycle
//   vectors carries inputs and the required r_data after that cycle's edge;
//   the required value is queued when the vector is driven and popped and
//   compared after the edge. Reset behaviour is exercised by hand-written
//   sequences around the table.
// ----------------------------------------------------------------------------
module tb_ram_behavior;

    localparam int AW = 5;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          r_en;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;

    ram_behavior #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .w_en   (w_en),
        .w_addr (w_addr),
        .w_data (w_data),
        .r_en   (r_en),
        .r_addr (r_addr),
        .r_data (r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          re;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp;
        string         name;
    } vec_t;

    typedef struct {
        logic [DW-1:0] exp;
        string         name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(input logic we, input int wa, input int wd,
                                input logic re, input int ra, input int exp,
                                input string name);
        vec_t v;
        v.we   = we;
        v.wa   = AW'(wa);
        v.wd   = DW'(wd);
        v.re   = re;
        v.ra   = AW'(ra);
        v.exp  = DW'(exp);
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: r_data=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle on the falling edge, queue the required result, then
    // compare 1 time unit after the rising edge.
    task automatic cycle(input logic we, input logic [AW-1:0] wa,
                         input logic [DW-1:0] wd, input logic re,
                         input logic [AW-1:0] ra, input logic [DW-1:0] exp,
                         input string name);
        sb_t e;
        sb_t got;
        @(negedge clk);
        w_en   = we;
        w_addr = wa;
        w_data = wd;
        r_en   = re;
        r_addr = ra;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            check(got.name, r_data, got.exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n  = 1'b0;
        w_en   = 1'b0;
        w_addr = '0;
        w_data = '0;
        r_en   = 1'b0;
        r_addr = '0;

        // ---- reset: writes and reads during reset are ignored ----
        #3;
        check("in_reset", r_data, 8'h00);
        w_en   = 1'b1;
        w_addr = 5'd20;
        w_data = 8'h77;
        r_en   = 1'b1;
        r_addr = 5'd20;
        #3;   // edge at t=5 occurs while in reset
        check("in_reset_edge", r_data, 8'h00);
        w_en = 1'b0;
        r_en = 1'b0;
        #6;   // release at t=12, held low for 12 units
        rst_n = 1'b1;
        #1;
        check("after_release", r_data, 8'h00);
        cycle(0, 0, 0, 0, 0, 8'h00, "idle_after_release");

`ifdef RAM_BEHAVIOR_RST_CLEAR_EN
        cycle(0, 0, 0, 1, 9,  8'h00, "unwritten_9");
        cycle(0, 0, 0, 1, 11, 8'h00, "unwritten_11");
        cycle(0, 0, 0, 1, 20, 8'h00, "write_in_reset_ignored");
`endif

        // ---- vector table ----
        for (int i = 0; i < 7; i++) begin
            add(1, i, i, 0, 0, 8'h00, $sformatf("wr%0d", i));
        end
        add(1, 7, 8'hFD, 0, 0, 8'h00, "wr7_fd");
        add(1, 8, 8'hFE, 0, 0, 8'h00, "wr8_fe");
        for (int i = 0; i < 6; i++) begin
            add(0, 0, 0, 1, i, i, $sformatf("rd%0d", i));
        end
        add(0, 0, 0, 1, 8, 8'hFE, "rd8");
        add(1, 9, 8'h5A, 0, 9, 8'hFE, "wr9_5a");
        add(0, 9, 8'h09, 0, 9, 8'hFE, "wen0_drive9");
        add(0, 0, 0, 1, 9, 8'h5A, "rd9_unchanged");
        add(0, 0, 0, 0, 0, 8'h5A, "ren0_hold_a");
        add(0, 0, 0, 0, 1, 8'h5A, "ren0_hold_b");
        add(0, 0, 0, 0, 31, 8'h5A, "ren0_hold_c");
        add(1, 10, 8'hC3, 1, 2, 8'h02, "wr10_rd2");
        add(0, 0, 0, 1, 10, 8'hC3, "rd10");
        add(1, 3, 8'hA5, 1, 3, 8'hA5, "collide3");
        add(0, 0, 0, 1, 3, 8'hA5, "rd3_after");
        add(1, 12, -3, 1, 12, 8'hFD, "collide12_neg3");
        add(0, 0, 0, 1, 7, 8'hFD, "rd7");
        add(1, 31, 8'h81, 1, 31, 8'h81, "collide31");
        add(0, 0, 0, 1, 0, 8'h00, "rd0_again");
        add(0, 0, 0, 1, 8, 8'hFE, "rd8_pre_reset");

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
                  vecs[i].exp, vecs[i].name);
        end

        // ---- reset mid-stream, between edges ----
        #2;
        check("pre_pulse_fe", r_data, 8'hFE);
        rst_n = 1'b0;
        #1;
        check("async_reset_clears", r_data, 8'h00);
        @(negedge clk);
        w_en   = 1'b1;
        w_addr = 5'd8;
        w_data = 8'h11;
        r_en   = 1'b1;
        r_addr = 5'd8;
        @(posedge clk);
        #1;
        check("reset_held_edge", r_data, 8'h00);
        #2;
        w_en  = 1'b0;
        r_en  = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_pulse_release", r_data, 8'h00);
        cycle(0, 0, 0, 0, 8, 8'h00, "post_pulse_idle");
`ifdef RAM_BEHAVIOR_RST_CLEAR_EN
        cycle(0, 0, 0, 1, 8, 8'h00, "rd8_after_clear");
`else
        cycle(0, 0, 0, 1, 8, 8'hFE, "rd8_retained");
`endif
        cycle(1, 8, 8'h3C, 1, 8, 8'h3C, "first_edges_normal");

        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
